// File: rtl/rr_mux_4_1.sv
// Four-lane round-robin multiplexer with a single registered output slot.
// Lanes use valid/ready handshakes; the output stage can be refilled in the same cycle it drains.
module rr_mux_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [3:0]   vld,
    output logic [3:0]   rdy,
    output logic [W-1:0] y,
    output logic         y_vld,
    input  logic         y_rdy,
    output logic [1:0]   sel
);

    logic [W-1:0] r_y;
    logic [1:0]   r_sel;
    logic         r_y_vld;
    logic [1:0]   r_ptr;

    logic         w_load;
    logic [1:0]   w_gnt;
    logic [W-1:0] w_data;

    // First valid lane found when searching upward from ptr, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + k[1:0];
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_gnt  = rr_pick(vld, r_ptr);
    assign w_load = !rst && (!r_y_vld || y_rdy) && (vld != 4'b0000);

    always_comb begin
        rdy = 4'b0000;
        if (w_load) begin
            rdy = 4'b0001 << w_gnt;
        end
    end

    always_comb begin
        w_data = d0;
        case (w_gnt)
            2'd0:    w_data = d0;
            2'd1:    w_data = d1;
            2'd2:    w_data = d2;
            default: w_data = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_sel   <= 2'd0;
            r_y_vld <= 1'b0;
            r_ptr   <= 2'd0;
        end else if (w_load) begin
            r_y     <= w_data;
            r_sel   <= w_gnt;
            r_y_vld <= 1'b1;
            r_ptr   <= w_gnt + 2'd1;
        end else if (r_y_vld && y_rdy) begin
            // Drain without refill: data and index stay put for observation.
            r_y_vld <= 1'b0;
        end
    end

    assign y     = r_y;
    assign y_vld = r_y_vld;
    assign sel   = r_sel;

endmodule

// File: doc/rr_mux_4_1.md
RR_MUX_4_1 -- requirements
Module: rr_mux_4_1

Interface
REQ-001 Parameter: W, default 4, lane data width in bits.
REQ-002 Port: clk  input  1  clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: d0, d1, d2, d3  input  W each  lane data.
REQ-005 Port: vld  input  4  lane valid; bit i qualifies di.
REQ-006 Port: rdy  output  4  lane ready; bit i high means di is taken this cycle.
REQ-007 Port: y  output  W  registered selected data.
REQ-008 Port: y_vld  output  1  y holds a valid item.
REQ-009 Port: y_rdy  input  1  downstream accepts y this cycle.
REQ-010 Port: sel  output  2  registered index of the lane that produced y.

Function
REQ-011 Lane i transfer SHALL occur when vld[i] and rdy[i] are both high at a rising edge; output transfer SHALL occur when y_vld and y_rdy are both high.
REQ-012 Internal signal load = (!y_vld || y_rdy) && (vld != 0); the block SHALL accept at most one lane per cycle, and only when load is high.
REQ-013 Grant SHALL be round-robin: search order starts at pointer ptr (2 bits), then ptr+1, ptr+2, ptr+3 mod 4; the first lane with vld set is granted.
REQ-014 rdy SHALL be one-hot on the granted lane when load is high, else all zero; rdy SHALL depend combinationally on vld, y_vld, y_rdy and ptr only.
REQ-015 On a load of lane g: y <= dg, sel <= g, y_vld <= 1, ptr <= (g+1) mod 4 (wrap 3 -> 0).
REQ-016 On an output transfer with no load in the same cycle: y_vld <= 0; y and sel SHALL hold their values.
REQ-017 Simultaneous output transfer and load SHALL replace the item with no bubble (y_vld stays 1), giving throughput of one item per cycle.
REQ-018 While y_vld=1 and y_rdy=0, y, sel, y_vld and ptr SHALL hold, and rdy SHALL be 0.
REQ-019 Latency: lane data accepted at edge N SHALL appear on y with y_vld=1 immediately after edge N (one register stage).
REQ-020 ptr SHALL change only on a load; an idle cycle (vld=0) SHALL not move it.
REQ-021 A lane whose vld is deasserted before transfer SHALL simply lose the grant; no state is kept for it.
REQ-022 No lane SHALL wait more than 3 loads while continuously valid (starvation-free).

Reset
REQ-023 While rst=1 at a rising edge: y_vld <= 0, y <= 0, sel <= 0, ptr <= 0; rst SHALL take precedence over any transfer in the same cycle.
REQ-024 During rst=1, rdy SHALL be forced to 0 so no lane item is consumed.
REQ-025 Reset asserted mid-stream SHALL drop the held item; the first grant after reset SHALL start search at lane 0.

Verification
REQ-026 Reset, then vld=4'b1111, d0..d3=1,2,3,4, y_rdy=1 constantly -> y sequence 1,2,3,4,1,... sel 0,1,2,3,0, one item per cycle, y_vld stays 1.
REQ-027 vld=4'b1010, y_rdy=1 -> grants alternate lane 1, lane 3, lane 1; rdy alternates 4'b0010, 4'b1000.
REQ-028 Load lane 2 (d2=4'hA), then y_rdy=0 for 3 cycles while vld=4'b1111 -> y=4'hA, sel=2 held, rdy=0 throughout; y_rdy=1 -> next grant lane 3.
REQ-029 vld=0 for several cycles after a lane 0 grant, then vld=4'b0001 -> grant lane 0 (search from ptr=1 wraps to 0); ptr unchanged during idle.
REQ-030 Assert rst for one cycle while y_vld=1, vld=4'b1111, y_rdy=0 -> next cycle y_vld=0, y=0, sel=0, rdy=0 during reset; first post-reset grant is lane 0.
REQ-031 Output transfer with vld=0 -> y_vld drops to 0 next cycle, y and sel retain last values.
